// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Arbitrates the register file's single write port between two writeback
// requesters (0 = ALU, 1 = load) over a valid/ready handshake. The winning
// address/data is registered and decoded into a one-hot write-enable vector,
// one bit per register, so no external decoder is needed. Register 0 is
// hardwired to zero: writes to it are accepted but never issued.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall                 blocks all grants while high
//   reqN_valid/addr/data  requester N write request (N = 0 ALU, 1 load)
//   reqN_ready            requester N granted this cycle (combinational)
//   wr_en/wr_addr/wr_data registered write issued this cycle
//   wr_en_vec             one-hot enable, bit i drives regWrite of register i
//
// Configuration macro:
//   REGARB_FIXED_PRIO_EN  defined: requester 1 always wins contention
//                         undefined (default): round-robin arbitration
module regfile_write_arbiter #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 req0_valid,
    input  logic [AW-1:0]        req0_addr,
    input  logic [DW-1:0]        req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [AW-1:0]        req1_addr,
    input  logic [DW-1:0]        req1_data,
    output logic                 req1_ready,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic [(2**AW)-1:0]   wr_en_vec
);

    logic          handshake;
    logic [AW-1:0] grant_addr;
    logic [DW-1:0] grant_data;

`ifndef REGARB_FIXED_PRIO_EN
    // Index of the most recent winner; the other requester wins the next tie.
    logic last_q;
`endif

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset && !stall) begin
`ifdef REGARB_FIXED_PRIO_EN
            req1_ready = req1_valid;
            req0_ready = req0_valid && !req1_valid;
`else
            req0_ready = req0_valid && (!req1_valid || last_q);
            req1_ready = req1_valid && (!req0_valid || !last_q);
`endif
        end
    end

    // Readies are mutually exclusive, so either one marks a handshake.
    assign handshake  = req0_ready || req1_ready;
    assign grant_addr = req1_ready ? req1_addr : req0_addr;
    assign grant_data = req1_ready ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
`ifndef REGARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            // Address 0 is consumed without producing a write.
            wr_en <= handshake && (grant_addr != '0);
            if (handshake) begin
                wr_addr <= grant_addr;
                wr_data <= grant_data;
`ifndef REGARB_FIXED_PRIO_EN
                last_q  <= req1_ready;
`endif
            end
        end
    end

    always_comb begin
        wr_en_vec = '0;
        if (wr_en) begin
            wr_en_vec[wr_addr] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [31:0]   wr_en_vec;

    regfile_write_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en_vec  (wr_en_vec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_last = 1;     // reference model: index of the last winner
    int   rst_chk = -1;   // cycle in which outputs must read zero after reset
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, check readies against the model, and
    // queue the write the output stage should issue one cycle later.
    task automatic step(input bit rs, input bit st,
                        input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                        output bit g0, output bit g1);
        exp_t e;
        @(negedge clk);
        reset = rs; stall = st;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rs && !st) begin
            if (v0 && v1) begin
`ifdef REGARB_FIXED_PRIO_EN
                g1 = 1'b1;
`else
                if (m_last == 1) g0 = 1'b1;
                else g1 = 1'b1;
`endif
            end else if (v0) begin
                g0 = 1'b1;
            end else if (v1) begin
                g1 = 1'b1;
            end
        end
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, g0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, g1});
        if (g0 || g1) begin
            m_last = g1 ? 1 : 0;
            e.due  = cyc + 1;
            e.addr = g1 ? a1 : a0;
            e.data = g1 ? d1 : d0;
            if (e.addr != 5'd0) exp_q.push_back(e);
        end
        if (rs) begin
            m_last  = 1;
            rst_chk = cyc + 1;
        end
    endtask

    // Monitor: compares every presented write against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst_chk == cyc) begin
                chk("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
                chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
            end
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                    chk("unexpected_write", {59'd0, wr_addr}, 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {59'd0, wr_addr}, {59'd0, e.addr});
                    chk("wr_data", {32'd0, wr_data}, {32'd0, e.data});
                    chk("wr_en_vec", {32'd0, wr_en_vec}, {32'd0, 32'd1 << e.addr});
                end
            end else begin
                chk("wr_en_idle", {63'd0, wr_en}, 64'd0);
                chk("wr_en_vec_idle", {32'd0, wr_en_vec}, 64'd0);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    chk("missing_write", {59'd0, e.addr}, 64'd0);
                end
            end
        end
    end

    initial begin
        bit g0, g1;
        bit p0, p1;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        bit [3:0] wins1;

        // Reset
        step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        mon_en = 1'b1;

        // Single ALU write to reg 5
        step(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Contention for 4 cycles from a fresh reset
        step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, g0, g1);
            wins1[i] = req1_ready;
        end
`ifdef REGARB_FIXED_PRIO_EN
        chk("contention_order", {60'd0, wins1}, 64'hF);
`else
        chk("contention_order", {60'd0, wins1}, 64'hA);
`endif

        // Load write to reg 0 is consumed silently
        step(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Grant to reg 3, then stall for 3 cycles with both valid
        step(0, 0, 1, 5'd3, 32'h3333, 0, 0, 0, g0, g1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, g0, g1);
        step(0, 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Grant followed by reset; next contention goes to requester 0
        step(0, 0, 0, 0, 0, 1, 5'd7, 32'h7777, g0, g1);
        step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA, g0, g1);
`ifdef REGARB_FIXED_PRIO_EN
        chk("post_reset_winner", {63'd0, req1_ready}, 64'd1);
`else
        chk("post_reset_winner", {63'd0, req0_ready}, 64'd1);
`endif
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Randomized traffic; losers hold their request until granted
        p0 = 0; p1 = 0;
        a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0 && $urandom_range(3) != 0) begin
                p0 = 1; a0 = 5'($urandom_range(31)); d0 = $urandom;
            end
            if (!p1 && $urandom_range(3) != 0) begin
                p1 = 1; a1 = 5'($urandom_range(31)); d1 = $urandom;
            end
            step(($urandom_range(59) == 0), ($urandom_range(5) == 0),
                 p0, a0, d0, p1, a1, d1, g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates the register file's single write port between two writeback requesters: requester 0 (ALU writeback) and requester 1 (load writeback). It accepts one write per cycle through a valid/ready handshake, then registers the winning address and data. The registered result drives a one-hot write-enable vector, one bit per 32-bit register. Each enable bit connects to the `regWrite` input of one register instance, so no external decoder is needed.

## Interface
Parameters:
- AW, 5 — register address width; the register file holds 2**AW registers.
- DW, 32 — data width of each register.

Ports:
- clk  input  1  — system clock; all state updates on the rising edge.
- reset  input  1  — synchronous, active-high reset.
- stall  input  1  — pipeline stall; while high, no requester is granted.
- req0_valid  input  1  — requester 0 (ALU) has a write pending.
- req0_addr  input  AW  — destination register for requester 0.
- req0_data  input  DW  — write data for requester 0.
- req0_ready  output  1  — requester 0 is granted this cycle.
- req1_valid  input  1  — requester 1 (load) has a write pending.
- req1_addr  input  AW  — destination register for requester 1.
- req1_data  input  DW  — write data for requester 1.
- req1_ready  output  1  — requester 1 is granted this cycle.
- wr_en  output  1  — a registered write is being issued this cycle.
- wr_addr  output  AW  — registered write address.
- wr_data  output  DW  — registered write data.
- wr_en_vec  output  2**AW  — one-hot write enable; bit i drives `regWrite` of register i.

## Operation
- Readies are combinational from the valids, `stall`, the round-robin pointer `last` and `reset`.
- At most one ready is high per cycle.
- Both readies are 0 while `reset` or `stall` is high.
- When exactly one valid is high and `stall` is low, that requester gets ready.
- When both valids are high, round-robin applies:
  - `last`=1: requester 0 wins.
  - `last`=0: requester 1 wins.
- A handshake is valid & ready on the same edge.
- On a handshake, `last` updates to the winner's index.
- With no handshake, `last` holds.
- Output stage on each edge:
  - wr_en ← handshake && (granted addr != 0).
  - wr_addr and wr_data load the granted address and data on a handshake; otherwise they hold.
- Register 0 is hardwired to zero:
  - A handshake to address 0 is accepted and consumed.
  - It produces no write: wr_en=0 and wr_en_vec=0.
- wr_en_vec = wr_en ? (1 << wr_addr) : 0.
  - It is decoded from the registered values.
  - Bit 0 is never set.
- A losing requester must hold valid, addr and data stable until it is granted.
- The block stores nothing beyond the output stage; there is no queue.
- The write port never back-pressures, so every granted write completes in the next cycle.

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, wr_en_vec=0.
  - `last`=1, so requester 0 wins the first contention.
  - req0_ready=0 and req1_ready=0 during reset.
- Latency: a handshake in cycle N gives wr_en and wr_en_vec high in cycle N+1. The register captures the data at the end of N+1.
- Throughput: one write per cycle. Two continuously valid requesters alternate 0,1,0,1…
- `stall` rising: the output stage already loaded still issues its write in the next cycle. No new grants are made while `stall` is high.
- Reset asserted mid-stream: any pending output write is discarded. Outputs read 0 in the cycle after the reset edge.
- Two requesters targeting the same address in consecutive cycles: both writes issue in grant order, and the later grant overwrites.

## Configuration
- REGARB_FIXED_PRIO_EN
  - Defined: requester 1 (load) always wins contention. `last` is not implemented. Requester 0 can starve while requester 1 stays valid.
  - Undefined (default): round-robin as described above.
  - All other behaviour is identical with or without the macro.

## Test plan
- Reset, then req0_valid=1, addr=5, data=0xDEADBEEF:
  - req0_ready=1 in the same cycle.
  - Next cycle: wr_en=1, wr_addr=5, wr_en_vec=0x00000020, wr_data=0xDEADBEEF.
- Both requesters valid for 4 cycles (addr 1/2, data 0x11/0x22):
  - Round-robin: grants go 0,1,0,1.
  - With REGARB_FIXED_PRIO_EN: grants go 1,1,1,1 and req0_ready stays 0.
- req1_valid=1, addr=0, data=0xFFFFFFFF:
  - req1_ready=1.
  - Next cycle wr_en=0 and wr_en_vec=0.
- Grant to addr 3 in cycle N, then stall=1 for 3 cycles with both requesters valid:
  - Write to reg 3 issues in N+1.
  - Readies stay 0 for the 3 cycles and wr_en is 0 afterwards.
  - After stall drops, arbitration resumes with the correct requester winning.
- Grant in cycle N, then reset=1 in cycle N+1:
  - wr_en=0, wr_en_vec=0 and wr_data=0 after the edge.
  - The next contention is won by requester 0.
